// File: rtl/moore_seq_tx_if.sv
// rtl/moore_seq_tx_if.sv - request/serial-line bundle between a stimulus client and moore_seq_tx
interface moore_seq_tx_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) ();
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;
  logic             exp_z;

  modport master (
    output start, pattern, reps,
    input  x, valid, busy, done, exp_z
  );

  modport slave (
    input  start, pattern, reps,
    output x, valid, busy, done, exp_z
  );
endinterface

// File: rtl/moore_seq_tx.sv
// rtl/moore_seq_tx.sv - repeating MSB-first pattern transmitter with golden overlapping-1011 Moore output
module moore_seq_tx #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic           clk,
  input  logic           reset,
  moore_seq_tx_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE} state_t;
  typedef enum logic [2:0] {M_S0, M_S1, M_S2, M_S3, M_S4} mstate_t;

  state_t           state_q, state_d;
  mstate_t          m_q, m_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             exp_z_q, exp_z_d;
  logic             line;

  // The shift register is zeroed outside SHIFT, so its MSB is the registered line itself.
  assign line      = shreg_q[WIDTH-1];
  assign bus.x     = line;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.exp_z = exp_z_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        shreg_d = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          pat_d  = bus.pattern;
          reps_d = bus.reps;
          if (bus.reps == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            shreg_d = bus.pattern;
            bit_d   = BIT_LAST;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (bit_q != '0) begin
          shreg_d = shreg_q << 1;
          bit_d   = bit_q - 1'b1;
        end else begin
          reps_d = reps_q - 1'b1;
          if (reps_q == REP_W'(1)) begin
            state_d = ST_DONE;
            shreg_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LAST;
            shreg_d = '0;
            valid_d = 1'b0;
          end else begin
            shreg_d = pat_q;
            bit_d   = BIT_LAST;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_SHIFT;
          shreg_d = pat_q;
          bit_d   = BIT_LAST;
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Golden detector watches the registered line every cycle, gaps and idle included.
  always_comb begin
    m_d = M_S0;
    case (m_q)
      M_S0:    m_d = line ? M_S1 : M_S0;
      M_S1:    m_d = line ? M_S1 : M_S2;
      M_S2:    m_d = line ? M_S3 : M_S0;
      M_S3:    m_d = line ? M_S4 : M_S2;
      M_S4:    m_d = line ? M_S1 : M_S2;
      default: m_d = M_S0;
    endcase
    exp_z_d = (m_d == M_S4);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      m_q     <= M_S0;
      shreg_q <= '0;
      pat_q   <= '0;
      reps_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exp_z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exp_z_q <= exp_z_d;
    end
  end
endmodule

// File: tb/tb_moore_seq_tx.sv
// tb/tb_moore_seq_tx.sv - directed bench for moore_seq_tx with a per-cycle frame-queue model
module tb_moore_seq_tx;
  localparam int WIDTH = 8;
  localparam int REP_W = 4;
  localparam int GAP   = 2;

  typedef struct packed {
    logic x;
    logic valid;
    logic busy;
    logic done;
  } frame_t;

  logic clk;
  logic reset;

  moore_seq_tx_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus_if ();

  moore_seq_tx #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  frame_t      exp_q[$];
  logic [3:0]  hist;
  int          n_vec;
  int          n_bad;
  int          cyc;
  logic [31:0] x_log, v_log, b_log, z_log, d_log;

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void push_f(logic x, logic v, logic b, logic d);
    frame_t f;
    f.x = x; f.valid = v; f.busy = b; f.done = d;
    exp_q.push_back(f);
  endfunction

  // Expected line for a whole transaction: idle cycle of the request, bits, gaps, done.
  task automatic pulse_start(logic [WIDTH-1:0] pat, logic [REP_W-1:0] r);
    bus_if.start   = 1'b1;
    bus_if.pattern = pat;
    bus_if.reps    = r;
    if (exp_q.size() == 0) begin
      push_f(1'b0, 1'b0, 1'b0, 1'b0);
      for (int rr = 0; rr < int'(r); rr++) begin
        for (int b = WIDTH - 1; b >= 0; b--) push_f(pat[b], 1'b1, 1'b1, 1'b0);
        if (rr < int'(r) - 1)
          for (int g = 0; g < GAP; g++) push_f(1'b0, 1'b0, 1'b1, 1'b0);
      end
      push_f(1'b0, 1'b0, 1'b0, 1'b1);
      cyc = 0;
      x_log = '0; v_log = '0; b_log = '0; z_log = '0; d_log = '0;
    end
    @(posedge clk);
    #1;
    bus_if.start   = 1'b0;
    bus_if.pattern = ~pat;
    bus_if.reps    = ~r;
  endtask

  task automatic wait_idle(string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin : cmp_blk
    frame_t e;
    logic   ez;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    ez = (hist == 4'b1011);
    chk("x",     32'(bus_if.x),     32'(e.x));
    chk("valid", 32'(bus_if.valid), 32'(e.valid));
    chk("busy",  32'(bus_if.busy),  32'(e.busy));
    chk("done",  32'(bus_if.done),  32'(e.done));
    chk("exp_z", 32'(bus_if.exp_z), 32'(ez));
    hist = {hist[2:0], e.x};
    if (cyc >= 0 && cyc < 32) begin
      x_log[cyc] = bus_if.x;
      v_log[cyc] = bus_if.valid;
      b_log[cyc] = bus_if.busy;
      z_log[cyc] = bus_if.exp_z;
      d_log[cyc] = bus_if.done;
    end
    cyc++;
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    cyc   = 99;
    hist  = '0;
    x_log = '0; v_log = '0; b_log = '0; z_log = '0; d_log = '0;
    reset          = 1'b0;
    bus_if.start   = 1'b0;
    bus_if.pattern = '0;
    bus_if.reps    = '0;
    #15;
    reset = 1'b1;
    repeat (4) @(negedge clk);

    @(posedge clk); #1;
    pulse_start(8'b1011_0110, 4'd1);
    wait_idle("one_rep");
    chk("one_rep_x",    x_log, 32'h0000_00DA);
    chk("one_rep_vld",  v_log, 32'h0000_01FE);
    chk("one_rep_busy", b_log, 32'h0000_01FE);
    chk("one_rep_z",    z_log, 32'h0000_0120);
    chk("one_rep_done", d_log, 32'h0000_0200);

    @(posedge clk); #1;
    pulse_start(8'b1011_0110, 4'd2);
    wait_idle("two_rep");
    chk("two_rep_x",    x_log, 32'h0003_68DA);
    chk("two_rep_vld",  v_log, 32'h0007_F9FE);
    chk("two_rep_busy", b_log, 32'h0007_FFFE);
    chk("two_rep_z",    z_log, 32'h0004_8120);
    chk("two_rep_done", d_log, 32'h0008_0000);

    @(posedge clk); #1;
    pulse_start(8'hA5, 4'd0);
    wait_idle("zero_rep");
    chk("zero_rep_done", d_log, 32'h0000_0002);
    chk("zero_rep_vld",  v_log, 32'h0);
    chk("zero_rep_busy", b_log, 32'h0);
    chk("zero_rep_z",    z_log, 32'h0);

    @(posedge clk); #1;
    pulse_start(8'b1011_0110, 4'd1);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(8'hFF, 4'd3);
    wait_idle("restart");
    repeat (30) @(negedge clk);
    chk("restart_x",    x_log, 32'h0000_00DA);
    chk("restart_vld",  v_log, 32'h0000_01FE);
    chk("restart_done", d_log, 32'h0000_0200);

    @(posedge clk); #1;
    pulse_start(8'b1011_0110, 4'd2);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_x",     32'(bus_if.x),     32'd0);
    chk("arst_valid", 32'(bus_if.valid), 32'd0);
    chk("arst_busy",  32'(bus_if.busy),  32'd0);
    chk("arst_done",  32'(bus_if.done),  32'd0);
    chk("arst_exp_z", 32'(bus_if.exp_z), 32'd0);
    exp_q.delete();
    hist = '0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pulse_start(8'b0101_1011, 4'd1);
    wait_idle("post_rst");
    chk("post_rst_x",    x_log, 32'h0000_01B4);
    chk("post_rst_z",    z_log, 32'h0000_0240);
    chk("post_rst_done", d_log, 32'h0000_0200);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
